// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle: control-unit request side, instruction
// memory read side, and the instruction-register / status outputs.
`timescale 1ns/1ps
interface instr_fetch_if;
    logic        fetch_req;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr_out;
    logic        IRWrite;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;
    logic [31:0] pc_plus4;

    // Fetch controller side: drives memory request and IR/status outputs
    modport master (
        input  fetch_req, pc_in, mem_ack, mem_rdata,
        output mem_req, mem_addr, instr_out, IRWrite, fetch_done,
               fetch_err, busy, pc_plus4
    );

    // Environment side: control unit plus instruction memory
    modport slave (
        output fetch_req, pc_in, mem_ack, mem_rdata,
        input  mem_req, mem_addr, instr_out, IRWrite, fetch_done,
               fetch_err, busy, pc_plus4
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch initiator: issues one memory read per accepted request,
// strobes IRWrite for the returned word, reports misalignment and timeouts.
`timescale 1ns/1ps
module instr_fetch_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Last wait-counter value before the read is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 32'd1);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 32'd0);

    state_t             state_q,      state_d;
    logic               mem_req_q,    mem_req_d;
    logic [31:0]        mem_addr_q,   mem_addr_d;
    logic [31:0]        instr_q,      instr_d;
    logic [31:0]        pc_plus4_q,   pc_plus4_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               irwrite_q,    irwrite_d;
    logic               fetch_err_q,  fetch_err_d;
    logic               busy_q,       busy_d;

    // Next-state and next-output computation for the fetch FSM
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fetch_req) begin
                    if (bus.pc_in[1:0] == 2'b00) begin
                        state_d    = ST_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = bus.pc_in;
                        cnt_d      = '0;
                    end else begin
                        state_d    = ST_ERR;
                        mem_req_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An ack on the final permitted cycle beats the timeout.
                if (bus.mem_ack) begin
                    instr_d    = bus.mem_rdata;
                    pc_plus4_d = mem_addr_q + 32'd4;
                    mem_req_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    mem_req_d  = 1'b0;
                    state_d    = ST_ERR;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        irwrite_d   = (state_d == ST_DONE);
        fetch_err_d = (state_d == ST_ERR);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            instr_q     <= 32'd0;
            pc_plus4_q  <= 32'd0;
            cnt_q       <= '0;
            irwrite_q   <= 1'b0;
            fetch_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            cnt_q       <= cnt_d;
            irwrite_q   <= irwrite_d;
            fetch_err_q <= fetch_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.instr_out  = instr_q;
    assign bus.IRWrite    = irwrite_q;
    assign bus.fetch_done = irwrite_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.busy       = busy_q;
    assign bus.pc_plus4   = pc_plus4_q;

endmodule
